// File: rtl/sdram_mem_arbiter.sv
// Two-master round-robin arbiter sharing one picorv32-style memory port towards the SDRAM
// bridge; one transaction in flight, with a watchdog that answers the master with ERR_DATA.
module sdram_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 16,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic [31:0] s_rdata,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_RESP  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic             WDOG_EN  = (TIMEOUT_CYCLES != 32'd0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);

    state_t           state_r, state_s;
    logic             grant_r, grant_s;
    logic             last_grant_r, last_grant_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             sel_s;
    logic             resp_fire_s;
    logic [31:0]      resp_data_s;
    logic             s_valid_s, m0_ready_s, m1_ready_s, timeout_err_s;
    logic [31:0]      s_addr_s, s_wdata_s, m0_rdata_s, m1_rdata_s;
    logic [3:0]       s_wstrb_s;

    // Next-state and next-output logic for the arbitration FSM
    always_comb begin
        state_s       = state_r;
        grant_s       = grant_r;
        last_grant_s  = last_grant_r;
        cnt_s         = cnt_r;
        s_valid_s     = s_valid;
        s_addr_s      = s_addr;
        s_wdata_s     = s_wdata;
        s_wstrb_s     = s_wstrb;
        m0_rdata_s    = m0_rdata;
        m1_rdata_s    = m1_rdata;
        m0_ready_s    = 1'b0;
        m1_ready_s    = 1'b0;
        timeout_err_s = timeout_err;
        resp_fire_s   = 1'b0;
        resp_data_s   = 32'h0000_0000;
        // With both requesting, the master that did not win last time is chosen
        sel_s         = (m0_valid && m1_valid) ? ~last_grant_r : m1_valid;

        case (state_r)
            ST_IDLE: begin
                if (m0_valid || m1_valid) begin
                    grant_s   = sel_s;
                    s_valid_s = 1'b1;
                    cnt_s     = {CNT_W{1'b0}};
                    s_addr_s  = sel_s ? m1_addr  : m0_addr;
                    s_wdata_s = sel_s ? m1_wdata : m0_wdata;
                    s_wstrb_s = sel_s ? m1_wstrb : m0_wstrb;
                    state_s   = ST_BUSY;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                cnt_s = cnt_r + CNT_W'(1'b1);
                // A bridge answer on the expiry cycle still counts as a normal response
                if (s_ready) begin
                    s_valid_s   = 1'b0;
                    resp_fire_s = 1'b1;
                    resp_data_s = s_rdata;
                    state_s     = ST_RESP;
                end else if (WDOG_EN && (cnt_r == CNT_LAST)) begin
                    s_valid_s     = 1'b0;
                    timeout_err_s = 1'b1;
                    resp_fire_s   = 1'b1;
                    resp_data_s   = ERR_DATA;
                    state_s       = ST_DRAIN;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_RESP: begin
                last_grant_s = grant_r;
                state_s      = ST_IDLE;
            end
            ST_DRAIN: begin
                // The abandoned bridge access must finish before the port is reused
                if (s_ready) begin
                    last_grant_s = grant_r;
                    state_s      = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        if (resp_fire_s) begin
            if (grant_r) begin
                m1_ready_s = 1'b1;
                m1_rdata_s = resp_data_s;
            end else begin
                m0_ready_s = 1'b1;
                m0_rdata_s = resp_data_s;
            end
        end else begin
            m0_ready_s = 1'b0;
            m1_ready_s = 1'b0;
        end
    end

    // State, counter and registered outputs; last_grant resets to 1 so m0 wins first
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r      <= ST_IDLE;
            grant_r      <= 1'b0;
            last_grant_r <= 1'b1;
            cnt_r        <= {CNT_W{1'b0}};
            s_valid      <= 1'b0;
            s_addr       <= 32'h0000_0000;
            s_wdata      <= 32'h0000_0000;
            s_wstrb      <= 4'h0;
            m0_ready     <= 1'b0;
            m1_ready     <= 1'b0;
            m0_rdata     <= 32'h0000_0000;
            m1_rdata     <= 32'h0000_0000;
            timeout_err  <= 1'b0;
        end else begin
            state_r      <= state_s;
            grant_r      <= grant_s;
            last_grant_r <= last_grant_s;
            cnt_r        <= cnt_s;
            s_valid      <= s_valid_s;
            s_addr       <= s_addr_s;
            s_wdata      <= s_wdata_s;
            s_wstrb      <= s_wstrb_s;
            m0_ready     <= m0_ready_s;
            m1_ready     <= m1_ready_s;
            m0_rdata     <= m0_rdata_s;
            m1_rdata     <= m1_rdata_s;
            timeout_err  <= timeout_err_s;
        end
    end

endmodule

// File: tb/tb_sdram_mem_arbiter.sv
// Randomized bench for sdram_mem_arbiter: masters and bridge are driven from a
// transaction-level model that predicts every output on every cycle.
module tb_sdram_mem_arbiter;

    localparam int          T   = 8;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        m0_valid = 1'b0, m1_valid = 1'b0;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_addr = 32'h0, m0_wdata = 32'h0, m1_addr = 32'h0, m1_wdata = 32'h0;
    logic [3:0]  m0_wstrb = 4'h0, m1_wstrb = 4'h0;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic        s_ready = 1'b0;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [31:0] s_rdata = 32'h0;
    logic        timeout_err;

    sdram_mem_arbiter #(
        .TIMEOUT_CYCLES(T),
        .CNT_W(16),
        .ERR_DATA(ERR)
    ) dut (
        .clk(clk), .nrst(nrst),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: cyc counts posedges since reset release; one transaction record
    int          cyc;
    bit          act;
    int          tk, tl, tg;       // grant edge, bridge latency in BUSY cycles, master
    logic [31:0] tdata;
    int          next_free;        // earliest posedge at which a new grant may happen
    int          last_g;
    bit   [1:0]  pend;
    logic [31:0] ra [2];
    logic [31:0] rw [2];
    logic [3:0]  rs [2];
    logic [31:0] exp_rd [2];
    bit          exp_to;
    bit   [1:0]  rdy_now;
    bit          sv_now;
    int          n_grant [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic int pick_latency();
        int r;
        r = int'($urandom_range(0, 9));
        if (r <= 5)      return int'($urandom_range(1, 5));
        else if (r <= 7) return T;                       // answer on the expiry cycle
        else if (r == 8) return T - 1;
        else             return T + int'($urandom_range(1, 4)); // bridge too slow
    endfunction

    task automatic model_check();
        int endc;
        endc    = tk + ((tl < T) ? tl : T);
        sv_now  = act && (cyc >= tk) && (cyc < endc);
        rdy_now = 2'b00;
        if (act && (cyc == endc)) begin
            rdy_now[tg] = 1'b1;
            exp_rd[tg]  = (tl <= T) ? tdata : ERR;
            if (tl > T) exp_to = 1'b1;
        end
        check_eq("s_valid", 32'(s_valid), 32'(sv_now));
        check_eq("m0_ready", 32'(m0_ready), 32'(rdy_now[0]));
        check_eq("m1_ready", 32'(m1_ready), 32'(rdy_now[1]));
        check_eq("m0_rdata", m0_rdata, exp_rd[0]);
        check_eq("m1_rdata", m1_rdata, exp_rd[1]);
        check_eq("timeout_err", 32'(timeout_err), 32'(exp_to));
        if (sv_now) begin
            check_eq("s_addr", s_addr, ra[tg]);
            check_eq("s_wdata", s_wdata, rw[tg]);
            check_eq("s_wstrb", 32'(s_wstrb), 32'(rs[tg]));
        end
    endtask

    task automatic drive_step(input bit force_both);
        bit [1:0] just;
        just = 2'b00;
        for (int m = 0; m < 2; m++) begin
            if (pend[m] && rdy_now[m]) begin
                pend[m] = 1'b0;
                just[m] = 1'b1;
            end
        end
        if (act && (cyc >= tk + tl)) act = 1'b0;
        for (int m = 0; m < 2; m++) begin
            if (!pend[m] && !just[m] && (force_both || $urandom_range(0, 2) == 0)) begin
                pend[m] = 1'b1;
                ra[m]   = $urandom;
                rw[m]   = $urandom;
                rs[m]   = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            end
        end
        s_ready = 1'b0;
        s_rdata = $urandom;
        if (act && (cyc + 1 == tk + tl)) begin
            s_ready = 1'b1;
            s_rdata = tdata;
        end
        if (!act && (cyc + 1 >= next_free) && (pend != 2'b00)) begin
            tg        = (pend == 2'b11) ? (1 - last_g) : (pend[1] ? 1 : 0);
            act       = 1'b1;
            tk        = cyc + 1;
            tl        = pick_latency();
            tdata     = $urandom;
            last_g    = tg;
            next_free = (tl <= T) ? (tk + tl + 2) : (tk + tl + 1);
            n_grant[tg]++;
        end
        m0_valid = pend[0]; m0_addr = ra[0]; m0_wdata = rw[0]; m0_wstrb = rs[0];
        m1_valid = pend[1]; m1_addr = ra[1]; m1_wdata = rw[1]; m1_wstrb = rs[1];
    endtask

    task automatic do_reset(input bit force_both);
        @(negedge clk);
        nrst = 1'b0;
        #1;
        check_eq("rst_s_valid", 32'(s_valid), 32'h0);
        check_eq("rst_m0_ready", 32'(m0_ready), 32'h0);
        check_eq("rst_m1_ready", 32'(m1_ready), 32'h0);
        check_eq("rst_timeout_err", 32'(timeout_err), 32'h0);
        check_eq("rst_s_addr", s_addr, 32'h0);
        check_eq("rst_s_wdata", s_wdata, 32'h0);
        check_eq("rst_s_wstrb", 32'(s_wstrb), 32'h0);
        check_eq("rst_m0_rdata", m0_rdata, 32'h0);
        check_eq("rst_m1_rdata", m1_rdata, 32'h0);
        m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
        repeat (2) @(negedge clk);
        nrst      = 1'b1;
        cyc       = 0;
        act       = 1'b0;
        tk        = 0;
        tl        = 0;
        tg        = 0;
        next_free = 1;
        last_g    = 1;
        pend      = 2'b00;
        exp_rd[0] = 32'h0;
        exp_rd[1] = 32'h0;
        exp_to    = 1'b0;
        rdy_now   = 2'b00;
        sv_now    = 1'b0;
        drive_step(force_both);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            model_check();
            drive_step(1'b0);
        end
    endtask

    initial begin
        int budget;
        n_grant[0] = 0;
        n_grant[1] = 0;

        // Simultaneous requests straight after reset: m0 must be served first
        do_reset(1'b1);
        check_eq("first_grant_m0", 32'(tg), 32'h0);
        run_cycles(600);

        // Reset while a transaction is on the bridge
        budget = 0;
        while (!sv_now && budget < 200) begin
            run_cycles(1);
            budget++;
        end
        check_eq("busy_reached", 32'(sv_now), 32'h1);
        run_cycles(2);
        do_reset(1'b1);
        check_eq("regrant_m0", 32'(tg), 32'h0);
        run_cycles(600);

        check_eq("m0_granted", 32'(n_grant[0] > 20), 32'h1);
        check_eq("m1_granted", 32'(n_grant[1] > 20), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
